// File: rtl/des_cbc_ctrl.sv
// -----------------------------------------------------------------------------
// des_cbc_ctrl
//
// Block-mode wrapper around an external DES core. Accepts one 64-bit block at
// a time, applies ECB or CBC chaining around the core, and returns the result
// through a valid/ready output handshake. A watchdog on the core response sets
// a sticky error that blocks further input until the chain register is
// reloaded.
//
// Ports
//   i_Clk        clock, rising edge
//   i_Rst        asynchronous reset, active low
//   i_Mode       0 = ECB, 1 = CBC (sampled at block accept)
//   i_fDec       1 = decrypt      (sampled at block accept)
//   i_Key        DES key          (sampled at block accept)
//   i_IVLoad     load chain register from i_IV and clear o_Err (IDLE only)
//   i_IV         initialisation vector
//   i_InValid    input block valid
//   o_InReady    input block ready (IDLE and no error)
//   i_InData     input block
//   o_OutValid   output block valid (OUTPUT state)
//   i_OutReady   output block ready
//   o_OutData    output block
//   o_CoreStart  one-cycle start pulse to the DES core
//   o_CoreDec    core direction
//   o_CoreKey    core key
//   o_CoreText   core input text
//   i_CoreDone   one-cycle completion pulse from the core
//   i_CoreText   core result, valid with i_CoreDone
//   o_Busy       high whenever the FSM is not in IDLE
//   o_Err        sticky core-timeout flag
//
// P_TIMEOUT is the number of WAIT cycles tolerated before the timeout fires;
// the WAIT counter is 6 bits wide, so the usable range is 1..64.
// -----------------------------------------------------------------------------
module des_cbc_ctrl #(
  parameter int P_TIMEOUT = 32
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Mode,
  input  logic        i_fDec,
  input  logic [63:0] i_Key,
  input  logic        i_IVLoad,
  input  logic [63:0] i_IV,
  input  logic        i_InValid,
  output logic        o_InReady,
  input  logic [63:0] i_InData,
  output logic        o_OutValid,
  input  logic        i_OutReady,
  output logic [63:0] o_OutData,
  output logic        o_CoreStart,
  output logic        o_CoreDec,
  output logic [63:0] o_CoreKey,
  output logic [63:0] o_CoreText,
  input  logic        i_CoreDone,
  input  logic [63:0] i_CoreText,
  output logic        o_Busy,
  output logic        o_Err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [5:0] CNT_LAST = 6'(P_TIMEOUT - 1);

  logic [1:0]  state_q,     state_d;
  logic        mode_q,      mode_d;
  logic        dec_q,       dec_d;
  logic [63:0] key_q,       key_d;
  logic [63:0] blk_q,       blk_d;
  logic [63:0] core_text_q, core_text_d;
  logic [63:0] chain_q,     chain_d;
  logic [5:0]  cnt_q,       cnt_d;
  logic [63:0] out_data_q,  out_data_d;
  logic        err_q,       err_d;

  logic        in_ready;
  logic        accept;
  logic [63:0] chain_sel;

  // Ready is also masked by the reset pin so every handshake output reads
  // low while reset is held.
  assign in_ready  = (state_q == S_IDLE) && !err_q;
  assign accept    = in_ready && i_InValid;

  // An IV load in the accept cycle applies to the block being accepted.
  assign chain_sel = i_IVLoad ? i_IV : chain_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    dec_d       = dec_q;
    key_d       = key_q;
    blk_d       = blk_q;
    core_text_d = core_text_q;
    chain_d     = chain_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_IVLoad) begin
          chain_d = i_IV;
          err_d   = 1'b0;
        end
        if (accept) begin
          mode_d = i_Mode;
          dec_d  = i_fDec;
          key_d  = i_Key;
          blk_d  = i_InData;
          // Only CBC encrypt whitens the plaintext before the core.
          if (i_Mode && !i_fDec) begin
            core_text_d = i_InData ^ chain_sel;
          end else begin
            core_text_d = i_InData;
          end
          state_d = S_START;
        end
      end

      S_START: begin
        cnt_d   = 6'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (i_CoreDone) begin
          // Only CBC decrypt unwhitens the core output.
          if (mode_q && dec_q) begin
            out_data_d = i_CoreText ^ chain_q;
          end else begin
            out_data_d = i_CoreText;
          end
          // CBC chains on ciphertext: the core output when encrypting,
          // the captured input block when decrypting. ECB leaves it alone.
          if (mode_q) begin
            chain_d = dec_q ? blk_q : i_CoreText;
          end
          state_d = S_OUTPUT;
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the block; chain is deliberately left untouched.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_OUTPUT: begin
        if (i_OutReady) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      dec_q       <= 1'b0;
      key_q       <= '0;
      blk_q       <= '0;
      core_text_q <= '0;
      chain_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dec_q       <= dec_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      core_text_q <= core_text_d;
      chain_q     <= chain_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // Core-side operands come straight from the capture registers, which only
  // change on accept, so they stay stable for the whole START/WAIT span.
  assign o_CoreStart = (state_q == S_START);
  assign o_CoreDec   = dec_q;
  assign o_CoreKey   = key_q;
  assign o_CoreText  = core_text_q;

  assign o_InReady   = in_ready && i_Rst;
  assign o_OutValid  = (state_q == S_OUTPUT);
  assign o_OutData   = out_data_q;
  assign o_Busy      = (state_q != S_IDLE);
  assign o_Err       = err_q;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_cbc_ctrl
//
// Scoreboard bench for des_cbc_ctrl. The main process issues blocks and pushes
// the expected core input and expected output block into queues. A core
// responder pops the core-input queue when it sees o_CoreStart, and an output
// monitor pops the output queue on every output handshake.
//
// The stand-in core knows the two classic DES vectors for key
// 133457799BBCDFF1 and otherwise returns text XOR key.
// -----------------------------------------------------------------------------
module tb_des_cbc_ctrl;

  localparam int TO = 12;

  localparam logic [63:0] K  = 64'h133457799BBCDFF1;
  localparam logic [63:0] P  = 64'h0123456789ABCDEF;
  localparam logic [63:0] C  = 64'h85E813540F0AB405;
  localparam logic [63:0] KC = 64'h96DC442D94B66BF4;  // K ^ C
  localparam logic [63:0] FF = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] Z  = 64'h0;

  logic        i_Clk, i_Rst, i_Mode, i_fDec, i_IVLoad, i_InValid, i_OutReady;
  logic [63:0] i_Key, i_IV, i_InData, i_CoreText;
  logic        resp_done, stray_done;
  wire         i_CoreDone;
  logic        o_InReady, o_OutValid, o_CoreStart, o_CoreDec, o_Busy, o_Err;
  logic [63:0] o_OutData, o_CoreKey, o_CoreText;

  assign i_CoreDone = resp_done | stray_done;

  int n_vec = 0;
  int n_miss = 0;
  int start_cnt = 0;
  int blk_cnt = 0;
  bit core_en = 1'b1;
  int core_lat = 1;

  logic [63:0] core_q[$];
  logic [63:0] out_q[$];

  des_cbc_ctrl #(.P_TIMEOUT(TO)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Mode(i_Mode), .i_fDec(i_fDec),
    .i_Key(i_Key), .i_IVLoad(i_IVLoad), .i_IV(i_IV),
    .i_InValid(i_InValid), .o_InReady(o_InReady), .i_InData(i_InData),
    .o_OutValid(o_OutValid), .i_OutReady(i_OutReady), .o_OutData(o_OutData),
    .o_CoreStart(o_CoreStart), .o_CoreDec(o_CoreDec), .o_CoreKey(o_CoreKey),
    .o_CoreText(o_CoreText), .i_CoreDone(i_CoreDone), .i_CoreText(i_CoreText),
    .o_Busy(o_Busy), .o_Err(o_Err)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] core_fn(input logic dec, input logic [63:0] key,
                                          input logic [63:0] text);
    if (key == K && !dec && text == P) return C;
    if (key == K &&  dec && text == C) return P;
    return text ^ key;
  endfunction

  // Output monitor: one comparison per output handshake.
  always @(negedge i_Clk) begin
    if (o_OutValid && i_OutReady) begin
      blk_cnt++;
      if (out_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_out: got %h, no output expected", o_OutData);
      end else begin
        $display("block %0d: out %h", blk_cnt, o_OutData);
        chk("out_data", o_OutData, out_q.pop_front());
      end
    end
  end

  // Count every cycle o_CoreStart is high so a stretched pulse shows up.
  always @(negedge i_Clk) begin
    if (o_CoreStart) start_cnt++;
  end

  // Stand-in DES core.
  logic        r_dec;
  logic [63:0] r_key, r_text;
  initial begin
    resp_done  = 1'b0;
    i_CoreText = '0;
    forever begin
      @(posedge i_Clk);
      #1;
      if (core_en && o_CoreStart) begin
        r_dec  = o_CoreDec;
        r_key  = o_CoreKey;
        r_text = o_CoreText;
        if (core_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_core_start: got text %h", r_text);
        end else begin
          chk("core_text", r_text, core_q.pop_front());
        end
        for (int i = 0; i < core_lat; i++) begin
          @(posedge i_Clk);
          #1;
          if (i == 0) chk("start_one_cycle", 64'(o_CoreStart), 64'd0);
        end
        chk("core_text_hold", o_CoreText, r_text);
        chk("core_key_hold", o_CoreKey, r_key);
        chk("core_dec_hold", 64'(o_CoreDec), 64'(r_dec));
        resp_done  = 1'b1;
        i_CoreText = core_fn(r_dec, r_key, r_text);
        @(posedge i_Clk);
        #1;
        resp_done  = 1'b0;
        i_CoreText = 64'hDEADBEEFDEADBEEF;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (o_Busy && n < 200) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    chk("busy_done", 64'(o_Busy), 64'd0);
  endtask

  task automatic accept(input bit mode, input bit dec, input bit ivl,
                        input logic [63:0] iv, input logic [63:0] key,
                        input logic [63:0] data);
    int n = 0;
    while (!o_InReady && n < 100) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    chk("in_ready", 64'(o_InReady), 64'd1);
    i_Mode    = mode;
    i_fDec    = dec;
    i_Key     = key;
    i_InData  = data;
    i_IVLoad  = ivl;
    i_IV      = iv;
    i_InValid = 1'b1;
    @(posedge i_Clk);
    #1;
    i_InValid = 1'b0;
    i_IVLoad  = 1'b0;
    chk("busy_after_accept", 64'(o_Busy), 64'd1);
    chk("in_ready_in_flight", 64'(o_InReady), 64'd0);
  endtask

  task automatic send(input bit mode, input bit dec, input bit ivl,
                      input logic [63:0] iv, input logic [63:0] key,
                      input logic [63:0] data, input logic [63:0] exp_core,
                      input logic [63:0] exp_out, input bit junk_ivl);
    int s0;
    core_q.push_back(exp_core);
    out_q.push_back(exp_out);
    s0 = start_cnt;
    accept(mode, dec, ivl, iv, key, data);
    // Hold an IV load across the whole block; it must have no effect.
    if (junk_ivl) begin
      i_IVLoad = 1'b1;
      i_IV     = FF;
    end
    wait_idle();
    i_IVLoad = 1'b0;
    chk("start_pulses", 64'(start_cnt - s0), 64'd1);
  endtask

  initial begin
    int s0;
    int n;
    i_Rst      = 1'b0;
    i_Mode     = 1'b0;
    i_fDec     = 1'b0;
    i_Key      = '0;
    i_IV       = '0;
    i_IVLoad   = 1'b0;
    i_InData   = '0;
    i_InValid  = 1'b0;
    i_OutReady = 1'b1;
    stray_done = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", 64'(o_InReady), 64'd0);
    chk("rst_busy", 64'(o_Busy), 64'd0);
    chk("rst_out_valid", 64'(o_OutValid), 64'd0);
    chk("rst_err", 64'(o_Err), 64'd0);
    chk("rst_core_start", 64'(o_CoreStart), 64'd0);
    chk("rst_out_data", o_OutData, Z);
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst = 1'b1;
    #1;
    chk("rel_in_ready", 64'(o_InReady), 64'd1);
    @(posedge i_Clk);
    #1;

    // mode dec ivl iv key data exp_core exp_out junk
    core_lat = 1;
    send(0, 0, 0, Z, K, P, P, C, 0);     // ECB encrypt                chain 0
    send(1, 0, 1, P, K, Z, P, C, 0);     // CBC encrypt, IV with accept chain C
    send(1, 0, 0, Z, K, C, Z, K, 0);     // chain C used               chain K
    send(0, 0, 0, Z, K, P, P, C, 0);     // ECB ignores chain          chain K
    core_lat = 3;
    send(1, 0, 0, Z, K, K, Z, K, 0);     // ECB left chain at K        chain K
    send(1, 1, 1, Z, K, C, C, P, 0);     // CBC decrypt, IV 0          chain C
    send(0, 1, 0, Z, K, C, C, P, 0);     // ECB decrypt, no unwhiten   chain C
    send(1, 1, 0, Z, K, Z, Z, KC, 0);    // CBC decrypt with chain C   chain 0

    // Backpressure
    core_lat = 5;
    core_q.push_back(P);
    out_q.push_back(C);
    i_OutReady = 1'b0;
    accept(0, 0, 0, Z, K, P);
    n = 0;
    while (!o_OutValid && n < 50) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", 64'(o_OutValid), 64'd1);
    repeat (5) begin
      chk("bp_valid_hold", 64'(o_OutValid), 64'd1);
      chk("bp_data_hold", o_OutData, C);
      chk("bp_in_ready", 64'(o_InReady), 64'd0);
      @(posedge i_Clk);
      #1;
    end
    i_OutReady = 1'b1;
    @(posedge i_Clk);
    #1;
    chk("bp_idle_busy", 64'(o_Busy), 64'd0);
    chk("bp_idle_valid", 64'(o_OutValid), 64'd0);
    chk("bp_idle_ready", 64'(o_InReady), 64'd1);

    // IV load outside IDLE must be ignored
    send(1, 0, 0, Z, K, P, P, C, 1);     // chain C
    send(1, 0, 0, Z, K, C, Z, K, 0);     // chain K

    // Timeout
    core_en = 1'b0;
    s0 = start_cnt;
    accept(0, 0, 0, Z, K, P);
    repeat (TO) @(posedge i_Clk);
    #1;
    chk("to_err_early", 64'(o_Err), 64'd0);
    chk("to_busy_early", 64'(o_Busy), 64'd1);
    @(posedge i_Clk);
    #1;
    chk("to_err", 64'(o_Err), 64'd1);
    chk("to_busy", 64'(o_Busy), 64'd0);
    chk("to_in_ready", 64'(o_InReady), 64'd0);
    chk("to_start_pulses", 64'(start_cnt - s0), 64'd1);
    stray_done = 1'b1;                   // must be ignored in IDLE
    @(posedge i_Clk);
    #1;
    stray_done = 1'b0;
    repeat (3) begin
      chk("to_stray_busy", 64'(o_Busy), 64'd0);
      chk("to_ready_held", 64'(o_InReady), 64'd0);
      @(posedge i_Clk);
      #1;
    end
    i_IVLoad = 1'b1;
    i_IV     = P;
    @(posedge i_Clk);
    #1;
    i_IVLoad = 1'b0;
    chk("to_err_clear", 64'(o_Err), 64'd0);
    chk("to_ready_back", 64'(o_InReady), 64'd1);
    core_en = 1'b1;
    send(1, 0, 0, Z, K, P, Z, K, 0);     // chain P from IV load       chain K

    // Mid-block reset
    core_en = 1'b0;
    accept(0, 0, 0, Z, K, P);
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    #1;
    chk("mr_in_ready", 64'(o_InReady), 64'd0);
    chk("mr_busy", 64'(o_Busy), 64'd0);
    chk("mr_out_valid", 64'(o_OutValid), 64'd0);
    chk("mr_core_start", 64'(o_CoreStart), 64'd0);
    chk("mr_err", 64'(o_Err), 64'd0);
    chk("mr_out_data", o_OutData, Z);
    chk("mr_core_key", o_CoreKey, Z);
    chk("mr_core_text", o_CoreText, Z);
    chk("mr_core_dec", 64'(o_CoreDec), 64'd0);
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b1;
    #1;
    chk("mr_rel_ready", 64'(o_InReady), 64'd1);
    core_en  = 1'b1;
    core_lat = 2;
    send(0, 0, 0, Z, K, P, P, C, 0);     // ECB after reset
    send(1, 0, 0, Z, K, P, P, C, 0);     // chain cleared by reset

    repeat (4) @(posedge i_Clk);
    #1;
    chk("queues_empty", 64'(core_q.size() + out_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
